// File: rtl/network_if_if.sv
// network_if: {val,id} stream bundle with valid/ready handshake
//   val    payload, VAL_WIDTH bits
//   id     opaque tag, ID_WIDTH bits
//   valid  source has a beat
//   ready  sink accepts the beat
//   master drives val/id/valid, slave drives ready
interface network_if #(
    parameter int VAL_WIDTH = 32,
    parameter int ID_WIDTH  = 8
);
    logic [VAL_WIDTH-1:0] val;
    logic [ID_WIDTH-1:0]  id;
    logic                 valid;
    logic                 ready;
    modport master (output val, id, valid, input ready);
    modport slave  (input val, id, valid, output ready);
endinterface

// File: rtl/network_if_fifo.sv
// network_if_fifo: synchronous FIFO buffering network_if beats with registered head output
//   clk, rst   clock and synchronous active-high reset
//   in         network_if.slave, write side; in.ready never depends on out.ready
//   out        network_if.master, read side; head comes from a register
//   level      occupancy (only with NETWORK_IF_FIFO_STATS_EN)
//   max_level  sticky occupancy high-water mark (only with NETWORK_IF_FIFO_STATS_EN)
module network_if_fifo #(
    parameter int DEPTH     = 8,
    parameter int VAL_WIDTH = 32,
    parameter int ID_WIDTH  = 8
) (
    input  logic      clk,
    input  logic      rst,
    network_if.slave  in,
    network_if.master out
`ifdef NETWORK_IF_FIFO_STATS_EN
    ,
    output logic [$clog2(DEPTH):0] level,
    output logic [$clog2(DEPTH):0] max_level
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int W  = VAL_WIDTH + ID_WIDTH;
    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);
    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  head_q, head_d;
    logic [AW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count, count_d;
    logic          push, pop;
    assign in.ready  = !rst && (count != FULL);
    assign out.valid = count != '0;
    assign {out.val, out.id} = head_q;
    // The head register is loaded with the beat that will be at the front after
    // this edge: the incoming beat when it lands in an otherwise empty FIFO,
    // otherwise the stored entry at the new read pointer; it holds while empty.
    always_comb begin
        count    = wr_ptr_q - rd_ptr_q;
        push     = in.valid && in.ready;
        pop      = out.valid && out.ready;
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};
        count_d  = wr_ptr_d - rd_ptr_d;
        head_d   = (push && rd_ptr_d == wr_ptr_q) ? {in.val, in.id}
                 : (count_d != '0) ? mem_q[rd_ptr_d[AW-1:0]] : head_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            head_q   <= head_d;
        end
    end
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= {in.val, in.id};
    end
`ifdef NETWORK_IF_FIFO_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            level     <= '0;
            max_level <= '0;
        end else begin
            level     <= count_d;
            max_level <= (count_d > max_level) ? count_d : max_level;
        end
    end
`endif
endmodule

// File: tb/tb_network_if_fifo.sv
// tb_network_if_fifo: vector table, directed corner sequences and random traffic vs a queue model
module tb_network_if_fifo;
    localparam int DEPTH = 8;
    logic clk = 0;
    logic rst = 1;
    always #5 clk = ~clk;
    network_if #(.VAL_WIDTH(32), .ID_WIDTH(8)) in_bus ();
    network_if #(.VAL_WIDTH(32), .ID_WIDTH(8)) out_bus ();
`ifdef NETWORK_IF_FIFO_STATS_EN
    logic [3:0] level, max_level;
`endif
    network_if_fifo #(.DEPTH(DEPTH), .VAL_WIDTH(32), .ID_WIDTH(8)) dut (
        .clk(clk),
        .rst(rst),
        .in(in_bus),
        .out(out_bus)
`ifdef NETWORK_IF_FIFO_STATS_EN
        ,
        .level(level),
        .max_level(max_level)
`endif
    );
    int tests = 0;
    int fails = 0;
    logic [39:0] q[$];
    int maxl = 0;
    bit dut_push, dut_pop;
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask
    // One clock: the model decides push/pop from the specification's rules,
    // then the DUT is compared with the model after the edge.
    task automatic cycle();
        bit mpush, mpop;
        mpush = !rst && in_bus.valid && q.size() < DEPTH;
        mpop  = !rst && q.size() > 0 && out_bus.ready;
        dut_push = in_bus.valid && in_bus.ready;
        dut_pop  = out_bus.valid && out_bus.ready;
        @(posedge clk);
        #1;
        if (rst) begin
            q.delete();
            maxl = 0;
        end else begin
            if (mpop) void'(q.pop_front());
            if (mpush) q.push_back({in_bus.val, in_bus.id});
            if (q.size() > maxl) maxl = q.size();
        end
        check("model_valid", 64'(out_bus.valid), 64'(q.size() != 0));
        check("model_ready", 64'(in_bus.ready), 64'(!rst && q.size() != DEPTH));
        if (q.size() != 0) check("model_data", 64'({out_bus.val, out_bus.id}), 64'(q[0]));
        else if (rst) check("model_rst_data", 64'({out_bus.val, out_bus.id}), 64'd0);
`ifdef NETWORK_IF_FIFO_STATS_EN
        check("model_level", 64'(level), 64'(q.size()));
        check("model_max_level", 64'(max_level), 64'(maxl));
`endif
    endtask
    typedef struct {
        logic        rst, iv;
        logic [31:0] v;
        logic [7:0]  id;
        logic        ordy, ev;
        logic [31:0] eval;
        logic [7:0]  eid;
        logic        erdy, chk;
    } vec_t;
    vec_t tbl[8];
    initial begin
        int pushed, popped;
        in_bus.valid = 0; in_bus.val = 0; in_bus.id = 0; out_bus.ready = 0;
        tbl[0] = '{1, 0, 32'h0,        8'h00, 1, 0, 32'h0,        8'h00, 0, 1};
        tbl[1] = '{0, 0, 32'h0,        8'h00, 1, 0, 32'h0,        8'h00, 1, 1};
        tbl[2] = '{0, 1, 32'hDEADBEEF, 8'h05, 1, 1, 32'hDEADBEEF, 8'h05, 1, 1};
        tbl[3] = '{0, 0, 32'h0,        8'h00, 1, 0, 32'h0,        8'h00, 1, 0};
        tbl[4] = '{0, 1, 32'h1,        8'h01, 0, 1, 32'h1,        8'h01, 1, 1};
        tbl[5] = '{0, 1, 32'h2,        8'h02, 0, 1, 32'h1,        8'h01, 1, 1};
        tbl[6] = '{0, 0, 32'h0,        8'h00, 1, 1, 32'h2,        8'h02, 1, 1};
        tbl[7] = '{0, 0, 32'h0,        8'h00, 1, 0, 32'h0,        8'h00, 1, 0};
        rst = 1;
        cycle();
        for (int i = 0; i < 8; i++) begin
            rst = tbl[i].rst; in_bus.valid = tbl[i].iv; in_bus.val = tbl[i].v;
            in_bus.id = tbl[i].id; out_bus.ready = tbl[i].ordy;
            cycle();
            check($sformatf("vec%0d_valid", i), 64'(out_bus.valid), 64'(tbl[i].ev));
            check($sformatf("vec%0d_ready", i), 64'(in_bus.ready), 64'(tbl[i].erdy));
            if (tbl[i].chk) begin
                check($sformatf("vec%0d_val", i), 64'(out_bus.val), 64'(tbl[i].eval));
                check($sformatf("vec%0d_id", i), 64'(out_bus.id), 64'(tbl[i].eid));
            end
        end
        // Fill past capacity with the consumer stalled, then drain in order.
        out_bus.ready = 0;
        for (int i = 1; i <= 10; i++) begin
            in_bus.valid = 1; in_bus.val = 32'(i); in_bus.id = 8'(i);
            cycle();
            check($sformatf("fill%0d_ready", i), 64'(in_bus.ready), 64'(i < 8));
        end
        in_bus.valid = 0; out_bus.ready = 1;
        for (int k = 1; k <= 8; k++) begin
            check($sformatf("drain%0d_val", k), 64'(out_bus.val), 64'(k));
            cycle();
            if (k == 1) check("ready_after_first_pop", 64'(in_bus.ready), 64'd1);
        end
        check("drained_valid", 64'(out_bus.valid), 64'd0);
        // Full FIFO with continuous push and pop: one pop per cycle, wraps several times.
        out_bus.ready = 0; in_bus.valid = 1;
        for (int i = 0; i < 8; i++) begin
            in_bus.val = 32'h1000 + 32'(i); in_bus.id = 8'(i);
            cycle();
        end
        out_bus.ready = 1; pushed = 0; popped = 0;
        for (int i = 0; i < 32; i++) begin
            in_bus.val = 32'h2000 + 32'(i); in_bus.id = 8'(i + 8);
            cycle();
            pushed += int'(dut_push);
            popped += int'(dut_pop);
        end
        check("stream_pops", 64'(popped), 64'd32);
        check("stream_pushes", 64'(pushed), 64'd31);
        in_bus.valid = 0;
        repeat (8) cycle();
        // Reset mid-stream with five beats buffered.
        out_bus.ready = 0; in_bus.valid = 1;
        for (int i = 0; i < 5; i++) begin
            in_bus.val = 32'h100 + 32'(i); in_bus.id = 8'(i);
            cycle();
        end
        in_bus.valid = 0; rst = 1;
        cycle();
        check("rst_valid", 64'(out_bus.valid), 64'd0);
        check("rst_ready", 64'(in_bus.ready), 64'd0);
        rst = 0; out_bus.ready = 1;
        cycle();
        check("post_rst_valid", 64'(out_bus.valid), 64'd0);
        check("post_rst_ready", 64'(in_bus.ready), 64'd1);
        in_bus.valid = 1; in_bus.val = 32'hCAFE; in_bus.id = 8'h33;
        cycle();
        in_bus.valid = 0;
        check("post_rst_new_val", 64'(out_bus.val), 64'hCAFE);
        check("post_rst_new_id", 64'(out_bus.id), 64'h33);
        cycle();
`ifdef NETWORK_IF_FIFO_STATS_EN
        out_bus.ready = 0; in_bus.valid = 1;
        for (int i = 0; i < 6; i++) begin
            in_bus.val = 32'(i); in_bus.id = 8'(i);
            cycle();
        end
        check("stats_peak_level", 64'(level), 64'd6);
        in_bus.valid = 0; out_bus.ready = 1;
        repeat (6) cycle();
        check("stats_end_level", 64'(level), 64'd0);
        check("stats_max_level", 64'(max_level), 64'd6);
        rst = 1;
        cycle();
        rst = 0;
        check("stats_max_after_rst", 64'(max_level), 64'd0);
`endif
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 59) == 0);
            in_bus.valid = $urandom_range(0, 2) != 0;
            in_bus.val = $urandom;
            in_bus.id = 8'($urandom);
            out_bus.ready = $urandom_range(0, 2) == 0 || i > 300;
            cycle();
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
